// File: rtl/ex_stage_if.sv
// ID/EX to EX bundle: decoded operands and control.
// The stall return path flows back to the upstream stages.
interface ex_stage_if;
  logic        hit;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] signExImmediate;
  logic [31:0] nextPC;
  logic        RegDst;
  logic        ALUSrc;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic [2:0]  ALUOp;
  logic [4:0]  rd;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic        stall;

  modport master (
    output hit, readData1, readData2,
    output signExImmediate, nextPC,
    output RegDst, ALUSrc, MemtoReg,
    output RegWrite, MemRead, MemWrite,
    output Branch, ALUOp, rd, rt, funct,
    input  stall
  );

  modport slave (
    input  hit, readData1, readData2,
    input  signExImmediate, nextPC,
    input  RegDst, ALUSrc, MemtoReg,
    input  RegWrite, MemRead, MemWrite,
    input  Branch, ALUOp, rd, rt, funct,
    output stall
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target, HI/LO and a
// fixed-latency mult/div unit feeding the EX/MEM register.
module ex_stage #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_stage_if.slave   id_ex,
  output logic [31:0] aluResultOut,
  output logic [31:0] writeDataOut,
  output logic [4:0]  writeRegOut,
  output logic [31:0] branchTargetOut,
  output logic        zeroOut,
  output logic        MemtoRegOut,
  output logic        RegWriteOut,
  output logic        MemReadOut,
  output logic        MemWriteOut,
  output logic        BranchOut,
  output logic        validOut,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic        mdBusy
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [31:0]   rt_val;
  logic [4:0]    shamt;
  logic          is_r;
  logic          md_op;
  logic          md_rd;
  logic          fire;
  logic          issue;
  logic [31:0]   alu;
  logic [31:0]   md_a;
  logic [31:0]   md_b;
  logic [1:0]    md_kind;
  logic [CW-1:0] count;
  logic [31:0]   md_hi;
  logic [31:0]   md_lo;
  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;

  assign rt_val = id_ex.readData2;
  assign shamt  = id_ex.signExImmediate[10:6];
  assign op_a   = id_ex.readData1;
  assign op_b   = id_ex.ALUSrc ? id_ex.signExImmediate
                               : rt_val;

  // Decode mult/div class and the hazard on busy HI/LO.
  always_comb begin
    is_r  = id_ex.ALUOp == 3'b010;
    md_op = is_r && (id_ex.funct[5:2] == 4'b0110);
    md_rd = is_r && (id_ex.funct == 6'h10 ||
                     id_ex.funct == 6'h12);
    id_ex.stall = id_ex.hit && mdBusy &&
                  (md_op || md_rd);
    fire  = id_ex.hit && !id_ex.stall;
    issue = fire && md_op;
  end

  // ALU result selection from ALUOp and funct.
  always_comb begin
    alu = 32'h0;
    case (id_ex.ALUOp)
      3'b000: alu = op_a + op_b;
      3'b001: alu = op_a - op_b;
      3'b011: alu = op_a & op_b;
      3'b100: alu = op_a | op_b;
      3'b101: alu = {31'h0,
                     $signed(op_a) < $signed(op_b)};
      3'b110: alu = {id_ex.signExImmediate[15:0],
                     16'h0};
      3'b010: begin
        case (id_ex.funct)
          6'h20, 6'h21: alu = op_a + op_b;
          6'h22, 6'h23: alu = op_a - op_b;
          6'h24: alu = op_a & op_b;
          6'h25: alu = op_a | op_b;
          6'h26: alu = op_a ^ op_b;
          6'h27: alu = ~(op_a | op_b);
          6'h2A: alu = {31'h0,
                        $signed(op_a) < $signed(op_b)};
          6'h2B: alu = {31'h0, op_a < op_b};
          6'h00: alu = rt_val << shamt;
          6'h02: alu = rt_val >> shamt;
          6'h03: alu = $unsigned(
                         $signed(rt_val) >>> shamt);
          6'h10: alu = hiOut;
          6'h12: alu = loOut;
          default: alu = 32'h0;
        endcase
      end
      default: alu = 32'h0;
    endcase
  end

  // Mult/div result from the latched operands.
  always_comb begin
    sa     = {{32{md_a[31]}}, md_a};
    sb     = {{32{md_b[31]}}, md_b};
    prod_s = sa * sb;
    prod_u = {32'h0, md_a} * {32'h0, md_b};
    md_hi  = 32'h0;
    md_lo  = 32'h0;
    case (md_kind)
      2'b00: {md_hi, md_lo} = prod_s;
      2'b01: {md_hi, md_lo} = prod_u;
      2'b10: begin
        if (md_b == 32'h0) begin
          md_lo = 32'hFFFF_FFFF;
          md_hi = md_a;
        end else if (md_a == 32'h8000_0000 &&
                     md_b == 32'hFFFF_FFFF) begin
          md_lo = 32'h8000_0000;
          md_hi = 32'h0;
        end else begin
          md_lo = $unsigned(
                    $signed(md_a) / $signed(md_b));
          md_hi = $unsigned(
                    $signed(md_a) % $signed(md_b));
        end
      end
      default: begin
        if (md_b == 32'h0) begin
          md_lo = 32'hFFFF_FFFF;
          md_hi = md_a;
        end else begin
          md_lo = md_a / md_b;
          md_hi = md_a % md_b;
        end
      end
    endcase
  end

  // EX/MEM register; bubbles clear control, hold data.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluResultOut    <= 32'h0;
      writeDataOut    <= 32'h0;
      writeRegOut     <= 5'h0;
      branchTargetOut <= 32'h0;
      zeroOut         <= 1'b0;
      MemtoRegOut     <= 1'b0;
      RegWriteOut     <= 1'b0;
      MemReadOut      <= 1'b0;
      MemWriteOut     <= 1'b0;
      BranchOut       <= 1'b0;
      validOut        <= 1'b0;
    end else begin
      validOut    <= fire;
      RegWriteOut <= fire && id_ex.RegWrite && !md_op;
      MemReadOut  <= fire && id_ex.MemRead;
      MemWriteOut <= fire && id_ex.MemWrite;
      BranchOut   <= fire && id_ex.Branch;
      if (fire) begin
        aluResultOut    <= alu;
        writeDataOut    <= rt_val;
        writeRegOut     <= id_ex.RegDst ? id_ex.rd
                                        : id_ex.rt;
        branchTargetOut <= id_ex.nextPC +
                           (id_ex.signExImmediate << 2);
        zeroOut         <= id_ex.readData1 ==
                           id_ex.readData2;
        MemtoRegOut     <= id_ex.MemtoReg;
      end
    end
  end

  // Mult/div sequencing and HI/LO writeback.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_a    <= 32'h0;
      md_b    <= 32'h0;
      md_kind <= 2'b00;
      count   <= '0;
      mdBusy  <= 1'b0;
      hiOut   <= 32'h0;
      loOut   <= 32'h0;
    end else if (issue) begin
      md_a    <= id_ex.readData1;
      md_b    <= id_ex.readData2;
      md_kind <= id_ex.funct[1:0];
      count   <= CW'(MD_CYCLES);
      mdBusy  <= 1'b1;
    end else if (mdBusy) begin
      count <= count - CW'(1);
      if (count == CW'(1)) begin
        hiOut  <= md_hi;
        loOut  <= md_lo;
        mdBusy <= 1'b0;
      end
    end
  end

endmodule
